// File: rtl/board_dump.sv
// board_dump: streams all 64 cells of the board RAM to a ready/valid
// consumer, one cell per read/load/send round trip.
// Optional BOARD_DUMP_COUNT_EN builds black/white cell counters; without it
// cnt_black and cnt_white are tied to zero.
module board_dump (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       ram_re,
  output logic [5:0] ram_addr,
  input  logic [1:0] ram_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_addr,
  output logic [1:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [6:0] cnt_black,
  output logic [6:0] cnt_white
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic handshake;
  logic last_cell;
  logic scan_start;

  assign handshake  = out_valid && out_ready;
  assign last_cell  = (out_addr == 6'd63);
  assign scan_start = (state == S_IDLE) && start;
  assign out_last   = last_cell && out_valid;

  // State register; reset drops any scan in flight back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded strobes; start is only honoured in idle.
  always_comb begin
    state_next = state;
    ram_re     = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        ram_re     = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        state_next = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = last_cell ? S_IDLE : S_READ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Read pointer: cleared on an accepted start, advanced per accepted cell, parked at 63 after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= 6'd0;
    end else if (scan_start) begin
      ram_addr <= 6'd0;
    end else if (handshake && !last_cell) begin
      ram_addr <= ram_addr + 6'd1;
    end
  end

  // Capture the RAM word and its address so they stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 2'd0;
      out_addr <= 6'd0;
    end else if (state == S_LOAD) begin
      out_data <= ram_rdata;
      out_addr <= ram_addr;
    end
  end

  // Completion pulse in the cycle after cell 63 is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= handshake && last_cell;
    end
  end

`ifdef BOARD_DUMP_COUNT_EN
  // Tally stones as each cell is loaded; value 11 is passed through but not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_black <= 7'd0;
      cnt_white <= 7'd0;
    end else if (scan_start) begin
      cnt_black <= 7'd0;
      cnt_white <= 7'd0;
    end else if (state == S_LOAD) begin
      if (ram_rdata == 2'b01) begin
        cnt_black <= cnt_black + 7'd1;
      end
      if (ram_rdata == 2'b10) begin
        cnt_white <= cnt_white + 7'd1;
      end
    end
  end
`else
  assign cnt_black = 7'd0;
  assign cnt_white = 7'd0;
`endif

endmodule

// File: tb/tb_board_dump.sv
// tb_board_dump: drives board_dump against a behavioural RAM and checks the
// streamed cells, handshake timing and stone counts against a reference
// derived directly from the RAM contents.
module tb_board_dump;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ram_re;
  logic [5:0] ram_addr;
  logic [1:0] ram_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_addr;
  logic [1:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [6:0] cnt_black;
  logic [6:0] cnt_white;

  logic [1:0] mem [64];

  int checks    = 0;
  int failures  = 0;
  int exp_black = 0;
  int exp_white = 0;

  board_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .cnt_black (cnt_black),
    .cnt_white (cnt_white)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Board RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  // Safety net in case something stalls the whole run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // kind 0: empty board, 1: sparse fixed pattern, 2: random cells incl. 11
  task automatic fillMem(input int kind);
    for (int a = 0; a < 64; a++) begin
      if (kind == 2) mem[a] = 2'($urandom_range(0, 3));
      else           mem[a] = 2'b00;
    end
    if (kind == 1) begin
      mem[5]  = 2'b01;
      mem[9]  = 2'b10;
      mem[63] = 2'b01;
    end
  endtask

  // Reference tally straight from the board contents.
  task automatic computeCounts();
    int b;
    int w;
    b = 0;
    w = 0;
    for (int a = 0; a < 64; a++) begin
      if (mem[a] == 2'b01) b++;
      if (mem[a] == 2'b10) w++;
    end
`ifdef BOARD_DUMP_COUNT_EN
    exp_black = b;
    exp_white = w;
`else
    exp_black = 0;
    exp_white = 0;
`endif
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ram_re"},    32'(ram_re),    32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
    checkOutput({tag, "_done"},      32'(done),      32'd0);
    checkOutput({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    checkOutput({tag, "_out_addr"},  32'(out_addr),  32'd0);
    checkOutput({tag, "_out_data"},  32'(out_data),  32'd0);
    checkOutput({tag, "_out_last"},  32'(out_last),  32'd0);
    checkOutput({tag, "_cnt_black"}, 32'(cnt_black), 32'd0);
    checkOutput({tag, "_cnt_white"}, 32'(cnt_white), 32'd0);
  endtask

  task automatic abortWithReset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    checkResetState("abort");
    repeat (2) begin
      stepCycle();
      checkOutput("abort_hold_done", 32'(done), 32'd0);
      checkOutput("abort_hold_busy", 32'(busy), 32'd0);
    end
    rst_n     = 1'b1;
    exp_black = 0;
    exp_white = 0;
  endtask

  // Idle cycles after a scan: nothing moves and the counters keep their value.
  task automatic idleCycles(input int k);
    repeat (k) begin
      stepCycle();
      checkOutput("idle_done",      32'(done),      32'd0);
      checkOutput("idle_busy",      32'(busy),      32'd0);
      checkOutput("idle_valid",     32'(out_valid), 32'd0);
      checkOutput("idle_ram_re",    32'(ram_re),    32'd0);
      checkOutput("idle_cnt_black", 32'(cnt_black), 32'(exp_black));
      checkOutput("idle_cnt_white", 32'(cnt_white), 32'(exp_white));
    end
  endtask

  // One scan: pulse start, then walk the stream cycle by cycle. Every cell must
  // come out in address order with its RAM value; each stalled cycle adds one
  // cycle to the 3-cycles-per-cell schedule. Ends in the done cycle unless a
  // reset is injected (reset_at) to abort the scan.
  task automatic applyStimulus(input int ready_mode, input int stall_at,
                               input int restart_at, input int reset_at);
    int n;
    int idx;
    int stalls;
    int reads;
    int first_valid;
    int last_hs;
    int stall_left;
    bit stall_used;
    bit ready;
    idx         = 0;
    stalls      = 0;
    reads       = 0;
    first_valid = -1;
    last_hs     = -1;
    stall_left  = 0;
    stall_used  = 1'b0;
    out_ready   = 1'b1;
    start       = 1'b1;
    stepCycle();
    start = 1'b0;
    n     = 1;
    checkOutput("first_re",      32'(ram_re),   32'd1);
    checkOutput("first_re_addr", 32'(ram_addr), 32'd0);
    while (n < 1000 && last_hs < 0) begin
      if (reset_at >= 0 && out_valid && out_addr == reset_at[5:0]) begin
        abortWithReset();
        return;
      end
      if (stall_at >= 0 && !stall_used && out_valid && out_addr == stall_at[5:0]) begin
        stall_left = 10;
        stall_used = 1'b1;
      end
      if (stall_left > 0)       ready = 1'b0;
      else if (ready_mode == 1) ready = ($urandom_range(0, 1) == 1);
      else                      ready = 1'b1;
      out_ready = ready;
      start     = (restart_at >= 0 && out_valid && out_addr == restart_at[5:0]);
      checkOutput("scan_done_early", 32'(done), 32'd0);
      checkOutput("scan_busy",       32'(busy), 32'd1);
      if (stall_left > 0) begin
        checkOutput("stall_valid",  32'(out_valid), 32'd1);
        checkOutput("stall_ram_re", 32'(ram_re),    32'd0);
        stall_left--;
      end
      if (ram_re) begin
        reads++;
        checkOutput("read_addr",     32'(ram_addr),  32'(idx));
        checkOutput("read_vs_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = n;
        checkOutput("out_addr", 32'(out_addr), 32'(idx));
        checkOutput("out_data", 32'(out_data), 32'(mem[idx]));
        checkOutput("out_last", 32'(out_last), 32'(idx == 63));
        if (ready) begin
          if (idx == 63) last_hs = n;
          idx++;
        end else begin
          stalls++;
        end
      end else begin
        checkOutput("out_last_idle", 32'(out_last), 32'd0);
      end
      stepCycle();
      n++;
    end
    start = 1'b0;
    if (last_hs < 0) begin
      checkOutput("scan_timeout", 32'd0, 32'd1);
      return;
    end
    computeCounts();
    checkOutput("first_valid_cycle", 32'(first_valid), 32'd3);
    checkOutput("scan_cycles",       32'(last_hs),     32'(192 + stalls));
    checkOutput("read_count",        32'(reads),       32'd64);
    checkOutput("done_pulse",        32'(done),        32'd1);
    checkOutput("done_busy",         32'(busy),        32'd0);
    checkOutput("done_valid",        32'(out_valid),   32'd0);
    checkOutput("done_ram_addr",     32'(ram_addr),    32'd63);
    checkOutput("done_cnt_black",    32'(cnt_black),   32'(exp_black));
    checkOutput("done_cnt_white",    32'(cnt_white),   32'(exp_white));
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fillMem(0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("reset");
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] empty board, consumer always ready");
    applyStimulus(0, -1, -1, -1);
    idleCycles(3);

    $display("[TB] sparse board with two black and one white stone");
    fillMem(1);
    applyStimulus(0, -1, -1, -1);
    idleCycles(3);

    $display("[TB] random board, consumer stalls on address 7");
    fillMem(2);
    applyStimulus(0, 7, -1, -1);
    idleCycles(2);

    $display("[TB] random board, start re-pulsed at address 20");
    fillMem(2);
    applyStimulus(0, -1, 20, -1);
    $display("[TB] start in the done cycle");
    fillMem(2);
    applyStimulus(0, -1, -1, -1);
    idleCycles(2);

    $display("[TB] random board, random backpressure");
    fillMem(2);
    applyStimulus(1, -1, -1, -1);
    idleCycles(2);

    $display("[TB] reset while presenting address 30");
    fillMem(2);
    applyStimulus(0, -1, -1, 30);
    idleCycles(3);
    fillMem(2);
    applyStimulus(0, -1, -1, -1);
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_dump.md
BOARD_DUMP -- requirements
Module: board_dump

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  request one full scan of the 64-cell board RAM
- ram_re  out  1  RAM read strobe
- ram_addr  out  6  RAM read address
- ram_rdata  in  2  RAM read data, valid the cycle after ram_re
- out_valid  out  1  cell output valid
- out_ready  in  1  downstream accepts cell
- out_addr  out  6  address of presented cell
- out_data  out  2  cell value (00 empty, 01 black, 10 white)
- out_last  out  1  presented cell is address 63
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion
- cnt_black  out  7  black cells in last or current scan
- cnt_white  out  7  white cells in last or current scan

Function
REQ-003 The FSM SHALL have states S_IDLE, S_READ, S_LOAD and S_SEND.
REQ-004 S_IDLE SHALL go to S_READ when start=1; it SHALL also clear ram_addr to 0 and clear both counters.
REQ-005 S_READ SHALL assert ram_re=1 for exactly one cycle at the current ram_addr, then go to S_LOAD.
REQ-006 S_LOAD SHALL register ram_rdata into out_data and ram_addr into out_addr, then go to S_SEND.
REQ-007 S_SEND SHALL hold out_valid=1 with out_data, out_addr and out_last stable until out_valid && out_ready.
REQ-008 On a handshake in S_SEND with out_addr<63, the block SHALL increment ram_addr and go to S_READ.
REQ-009 On a handshake in S_SEND with out_addr=63, the block SHALL go to S_IDLE, pulse done=1 in the next cycle, and hold ram_addr at 63.
REQ-010 out_valid SHALL be 1 only in S_SEND.
REQ-011 ram_re SHALL be 1 only in S_READ.
REQ-012 busy SHALL be 1 in every state except S_IDLE.
REQ-013 out_last SHALL equal (out_addr==63) && out_valid.
REQ-014 Latency: with start sampled at edge k, ram_re SHALL be high in cycle k+1 and the first out_valid in cycle k+3.
REQ-015 Throughput with out_ready held at 1 SHALL be one cell per 3 cycles; a full scan is 192 cycles from start edge to the last handshake.
REQ-016 start while busy=1 SHALL be ignored; it SHALL neither restart nor queue a scan.
REQ-017 start asserted in the same cycle as done SHALL be accepted, because the FSM is then in S_IDLE.
REQ-018 Deasserting out_ready SHALL only stall S_SEND; the block SHALL issue no RAM read while stalled.
REQ-019 ram_addr SHALL never wrap past 63 within a scan.

Reset
REQ-020 rst_n=0 SHALL immediately force:
- state to S_IDLE
- ram_addr, out_addr and out_data to 0
- ram_re, out_valid, busy and done to 0
- cnt_black and cnt_white to 0
REQ-021 Reset asserted mid-scan SHALL abort the scan with no done pulse; the next scan requires a new start.

Configuration
REQ-022 With macro BOARD_DUMP_COUNT_EN defined, the S_LOAD cycle SHALL increment cnt_black when ram_rdata=01 and cnt_white when ram_rdata=10.
REQ-023 With BOARD_DUMP_COUNT_EN defined, the value 11 SHALL be passed through on out_data and counted in neither counter.
REQ-024 With BOARD_DUMP_COUNT_EN defined, the counters SHALL hold their values after done until the next accepted start.
REQ-025 Without BOARD_DUMP_COUNT_EN, cnt_black and cnt_white SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour is unchanged.

Verification
REQ-026 The bench SHALL cover these scenarios:
- RAM all 00, out_ready=1, start pulse: 64 handshakes with out_addr 0..63 and out_data 00; out_last only at 63; done one cycle after the last handshake; 192 cycles from start edge to last handshake; counters 0.
- Cell 5=01, cell 9=10, cell 63=01, rest 00, with BOARD_DUMP_COUNT_EN: cnt_black=2 and cnt_white=1 at done; out_data correct per address.
- out_ready low for 10 cycles while presenting address 7: out_valid, out_addr=7 and out_data stable; ram_re stays 0 for those 10 cycles.
- start re-pulsed at address 20: ignored, scan continues and completes at 63; then start in the done cycle begins a new scan at address 0.
- rst_n low while presenting address 30: all outputs at reset values immediately; no done pulse; a following start scans from address 0.
- Same stimulus as the second scenario without the macro: cnt_black=cnt_white=0, streamed data identical.
